cpu_clken_ctrl: RTL and testbench



---
 rtl/cpu_clken_ctrl_if.sv | 26 ++
 rtl/cpu_clken_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_clken_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clken_ctrl_if.sv
// Command/divisor/status bundle between the debug monitor and the CPU clock-enable sequencer.
interface cpu_clken_ctrl_if #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 16
);
  logic               div_load;
  logic [DIV_W-1:0]   div_value;
  logic               cmd_valid;
  logic [1:0]         cmd;
  logic [BURST_W-1:0] burst_len;
  logic               cmd_ready;
  logic               cpu_clken;
  logic               halted;
  logic               done;
  logic [31:0]        cycle_count;

  modport master (
    output div_load, div_value, cmd_valid, cmd, burst_len,
    input  cmd_ready, cpu_clken, halted, done, cycle_count
  );

  modport slave (
    input  div_load, div_value, cmd_valid, cmd, burst_len,
    output cmd_ready, cpu_clken, halted, done, cycle_count
  );
endinterface

// File: rtl/cpu_clken_ctrl.sv
// CPU clock-enable run-control: programmable clk25 divider gated by HALT/RUN/STEP/BURST FSM.
// Optional CPU_CYCLE_COUNT_EN builds a 32-bit count of issued enables.
module cpu_clken_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 25,
  parameter bit RESET_RUN   = 1'b1,
  parameter int BURST_W     = 16
) (
  input logic             clk25,
  input logic             rst,
  cpu_clken_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_HALT  = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_BURST = 2'd3
  } cmd_t;

  localparam state_t RESET_STATE = RESET_RUN ? RUN : HALT;

  state_t             state, state_nxt;
  cmd_t               cmd_in;
  logic [DIV_W-1:0]   cnt, div_reg, pend_val, div_in;
  logic               pend;
  logic               tick, gate, accept;
  logic [BURST_W-1:0] burst_cnt, burst_nxt;
  logic               clken_q, clken_nxt;
  logic               done_q, done_nxt;

  assign cmd_in = cmd_t'(bus.cmd);
  assign div_in = (bus.div_value == '0) ? DIV_W'(1) : bus.div_value;
  assign tick   = (cnt == div_reg - DIV_W'(1));
  assign gate   = (state != HALT);

  assign bus.cmd_ready = (state == HALT) || (state == RUN);
  assign bus.halted    = (state == HALT);
  assign bus.cpu_clken = clken_q;
  assign bus.done      = done_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // New divisor only takes effect at a wrap so the running period is never cut short.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_reg  <= DIV_W'(DEFAULT_DIV);
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      if (tick) begin
        cnt  <= '0;
        pend <= 1'b0;
        if (bus.div_load)
          div_reg <= div_in;
        else if (pend)
          div_reg <= pend_val;
      end else begin
        cnt <= cnt + DIV_W'(1);
        if (bus.div_load) begin
          pend     <= 1'b1;
          pend_val <= div_in;
        end
      end
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state     <= RESET_STATE;
      burst_cnt <= '0;
      clken_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      clken_q   <= clken_nxt;
      done_q    <= done_nxt;
    end
  end

  // Enable in the accept cycle is gated by the state being left, not the one entered.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    clken_nxt = tick && gate;
    done_nxt  = 1'b0;
    unique case (state)
      HALT, RUN: begin
        if (accept) begin
          unique case (cmd_in)
            CMD_HALT: state_nxt = HALT;
            CMD_RUN:  state_nxt = RUN;
            CMD_STEP: state_nxt = STEP;
            CMD_BURST: begin
              if (bus.burst_len == '0) begin
                state_nxt = HALT;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = BURST;
                burst_nxt = bus.burst_len;
              end
            end
            default: state_nxt = state;
          endcase
        end
      end
      STEP: begin
        if (tick) begin
          state_nxt = HALT;
          done_nxt  = 1'b1;
        end
      end
      BURST: begin
        if (tick) begin
          burst_nxt = burst_cnt - BURST_W'(1);
          if (burst_cnt == BURST_W'(1)) begin
            state_nxt = HALT;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

`ifdef CPU_CYCLE_COUNT_EN
  logic [31:0] cyc;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst)
      cyc <= '0;
    else if (accept && cmd_in == CMD_RUN)
      cyc <= '0;
    else if (clken_q)
      cyc <= cyc + 32'd1;
  end

  assign bus.cycle_count = cyc;
`else
  assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clken_ctrl.sv
// Bench for cpu_clken_ctrl: directed scenarios then random traffic against a remaining-enables model.
module tb_cpu_clken_ctrl;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 25;
  localparam bit RESET_RUN   = 1'b1;
  localparam int BURST_W     = 16;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #20 clk25 = ~clk25;

  cpu_clken_ctrl_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  cpu_clken_ctrl #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .RESET_RUN  (RESET_RUN),
    .BURST_W    (BURST_W)
  ) dut (
    .clk25(clk25),
    .rst  (rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: m_left = enables still owed (-1 free-running, 0 halted, N owed by STEP/BURST).
  int          m_left, m_cnt, m_div, m_pval;
  bit          m_pend, m_clken, m_done;
  int unsigned m_cc;
  int          en_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left  = RESET_RUN ? -1 : 0;
    m_cnt   = 0;
    m_div   = DEFAULT_DIV;
    m_pend  = 1'b0;
    m_pval  = 0;
    m_clken = 1'b0;
    m_done  = 1'b0;
    m_cc    = 0;
  endtask

  task automatic compare_all();
    check("cpu_clken", 32'(bus.cpu_clken), 32'(m_clken));
    check("done",      32'(bus.done),      32'(m_done));
    check("halted",    32'(bus.halted),    32'(m_left == 0));
    check("cmd_ready", 32'(bus.cmd_ready), 32'(m_left <= 0));
`ifdef CPU_CYCLE_COUNT_EN
    check("cycle_count", bus.cycle_count, m_cc);
`else
    check("cycle_count", bus.cycle_count, 32'd0);
`endif
  endtask

  task automatic step(input bit v, input logic [1:0] c, input int bl, input bit ld, input int dv);
    bit          tick, acc, n_clken, n_done;
    int unsigned n_cc;
    bus.cmd_valid = v;
    bus.cmd       = c;
    bus.burst_len = BURST_W'(bl);
    bus.div_load  = ld;
    bus.div_value = DIV_W'(dv);
    tick    = (m_cnt == m_div - 1);
    acc     = v && (m_left <= 0);
    n_clken = tick && (m_left != 0);
    n_done  = 1'b0;
    n_cc    = (acc && c == 2'd1) ? 0 : (m_clken ? m_cc + 1 : m_cc);
    if (tick && m_left > 0) begin
      m_left--;
      if (m_left == 0) n_done = 1'b1;
    end
    if (acc) begin
      case (c)
        2'd0: m_left = 0;
        2'd1: m_left = -1;
        2'd2: m_left = 1;
        default: begin
          m_left = bl;
          if (bl == 0) n_done = 1'b1;
        end
      endcase
    end
    if (tick) begin
      m_cnt = 0;
      if (ld) m_div = (dv == 0) ? 1 : dv;
      else if (m_pend) m_div = m_pval;
      m_pend = 1'b0;
    end else begin
      m_cnt++;
      if (ld) begin
        m_pend = 1'b1;
        m_pval = (dv == 0) ? 1 : dv;
      end
    end
    @(posedge clk25);
    m_clken = n_clken;
    m_done  = n_done;
    m_cc    = n_cc;
    #1;
    bus.cmd_valid = 1'b0;
    bus.div_load  = 1'b0;
    @(negedge clk25);
    if (bus.cpu_clken) en_seen++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 0, 1'b0, 0);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk25);
    rst = 1'b0;
  endtask

  initial begin
    int first, en0, guard;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'd0;
    bus.burst_len = '0;
    bus.div_load  = 1'b0;
    bus.div_value = '0;
    model_reset();
    repeat (3) @(negedge clk25);
    compare_all();
    rst = 1'b0;

    // First enable lands DEFAULT_DIV cycles after release, then every DEFAULT_DIV.
    first = -1;
    for (int k = 1; k <= 60; k++) begin
      step(1'b0, 2'd0, 0, 1'b0, 0);
      if (bus.cpu_clken && first < 0) first = k;
    end
    check("first_clken_cycle", 32'(first), 32'(DEFAULT_DIV));

    step(1'b1, 2'd0, 0, 1'b0, 0);
    en0 = en_seen;
    idle(60);
    check("halt_no_enables", 32'(en_seen - en0), 32'd0);
    step(1'b1, 2'd2, 0, 1'b0, 0);
    idle(30);
    check("step_one_enable", 32'(en_seen - en0), 32'd1);

    step(1'b0, 2'd0, 0, 1'b1, 4);
    idle(30);
    en0 = en_seen;
    step(1'b1, 2'd3, 3, 1'b0, 0);
    idle(5);
    step(1'b1, 2'd1, 0, 1'b0, 0);
    idle(20);
    check("burst3_enables", 32'(en_seen - en0), 32'd3);

    en0 = en_seen;
    step(1'b1, 2'd3, 0, 1'b0, 0);
    check("burst0_done", 32'(bus.done), 32'd1);
    idle(10);
    check("burst0_no_enable", 32'(en_seen - en0), 32'd0);

    step(1'b1, 2'd1, 0, 1'b0, 0);
    idle(10);
    step(1'b0, 2'd0, 0, 1'b1, 0);
    idle(20);
    en0 = en_seen;
    idle(10);
    check("div0_every_cycle", 32'(en_seen - en0), 32'd10);

    step(1'b1, 2'd0, 0, 1'b1, 4);
    idle(10);
    en0 = en_seen;
    step(1'b1, 2'd3, 5, 1'b0, 0);
    guard = 0;
    while (en_seen - en0 < 3 && guard < 100) begin
      step(1'b0, 2'd0, 0, 1'b0, 0);
      guard++;
    end
    check("burst_progress_bound", 32'(guard < 100), 32'd1);
    async_reset();
    idle(30);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      step($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 4),
           $urandom_range(0, 30) == 0, $urandom_range(0, 9));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
